// File: rtl/ahb_arbiter_param.sv
// ahb_arbiter_param
// AHB bus arbiter for 2..16 masters. Selects one master per HREADY-qualified
// cycle using fixed-priority (index 0 highest) or round-robin policy, holds
// the grant for locked transfers, and masks masters whose transfer was SPLIT
// until the slave signals resume on HSPLIT.
//
// Ports:
//   HCLK       in   bus clock, all state changes on rising edge
//   HRESET     in   synchronous active-high reset
//   HBUSREQx   in   [NUM_MASTERS] per-master bus request
//   HLOCKx     in   [NUM_MASTERS] per-master locked-transfer request
//   HSPLIT     in   [NUM_MASTERS] split-resume, bit i unmasks master i
//   HREADY     in   transfer complete from selected slave
//   HRESP      in   [2] slave response, 2'b11 = SPLIT
//   HGRANTx    out  [NUM_MASTERS] one-hot grant
//   HMASTER    out  [MW] master owning the current address phase
//   HMASTLOCK  out  current address phase is locked
module ahb_arbiter_param #(
    parameter int NUM_MASTERS    = 16,
    parameter int ROUND_ROBIN    = 1,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] r_grant;
    logic [MW-1:0]          r_gidx;       // index form of r_grant
    logic [MW-1:0]          r_master;
    logic                   r_mastlock;
    logic [NUM_MASTERS-1:0] r_split_mask;
    logic [MW-1:0]          r_rr_ptr;

    logic [NUM_MASTERS-1:0] w_elig;
    logic                   w_lock_hold;
    logic [MW-1:0]          w_next_idx;
    logic [NUM_MASTERS-1:0] w_next_oh;
    logic                   w_req_grant;  // next grant goes to a requesting master
    logic [NUM_MASTERS-1:0] w_split_set;
    logic [MW-1:0]          w_i;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        w_i         = '0;
        w_elig      = HBUSREQx & ~r_split_mask;
        w_lock_hold = HLOCKx[r_gidx] & HBUSREQx[r_gidx];
        w_next_idx  = DEF_IDX;
        w_req_grant = 1'b0;
        if (w_lock_hold) begin
            w_next_idx  = r_gidx;
            w_req_grant = 1'b1;
        end else if (ROUND_ROBIN != 0) begin
            // Scan from farthest to nearest so the candidate closest after
            // rr_ptr is written last and wins; rr_ptr itself is scanned as
            // distance NUM_MASTERS, i.e. lowest priority.
            for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
                idx = 32'(r_rr_ptr) + k;
                if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
                w_i = MW'(idx);
                if (w_elig[w_i]) begin
                    w_next_idx  = w_i;
                    w_req_grant = 1'b1;
                end
            end
        end else begin
            // Highest index first so the lowest eligible index wins.
            for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
                w_i = MW'(k - 1);
                if (w_elig[w_i]) begin
                    w_next_idx  = w_i;
                    w_req_grant = 1'b1;
                end
            end
        end

        w_next_oh             = '0;
        w_next_oh[w_next_idx] = 1'b1;

        w_split_set = '0;
        if (!HREADY && HRESP == 2'b11) w_split_set[r_master] = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_grant      <= DEF_OH;
            r_gidx       <= DEF_IDX;
            r_master     <= DEF_IDX;
            r_mastlock   <= 1'b0;
            r_split_mask <= '0;
            r_rr_ptr     <= DEF_IDX;
        end else begin
            if (HREADY) begin
                r_grant    <= w_next_oh;
                r_gidx     <= w_next_idx;
                r_master   <= r_gidx;
                r_mastlock <= HLOCKx[r_gidx];
                if (w_req_grant) r_rr_ptr <= w_next_idx;
            end
            // Set is OR-ed in after the clear so a simultaneous set wins.
            r_split_mask <= (r_split_mask & ~HSPLIT) | w_split_set;
        end
    end

    assign HGRANTx   = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Bench for ahb_arbiter_param. Four instances share one stimulus stream:
//   c0: 4 masters fixed priority, default 0
//   c1: 4 masters round-robin, default 0
//   c2: 16 masters round-robin, default 5
//   c3: 2 masters round-robin, default 1
// A behavioural model predicts every instance each cycle; directed literal
// checks pin the model on the interesting scenarios.
module tb_ahb_arbiter_param;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req, lck, spl;
    logic        rdy;
    logic [1:0]  rsp;

    always #5 clk = ~clk;

    logic [3:0]  g0, g1;
    logic [15:0] g2;
    logic [1:0]  g3;
    logic [1:0]  m0, m1;
    logic [3:0]  m2;
    logic        m3;
    logic        l0, l1, l2, l3;

    ahb_arbiter_param #(.NUM_MASTERS(4), .ROUND_ROBIN(0), .DEFAULT_MASTER(0)) u_fp4 (
        .HCLK(clk), .HRESET(rst), .HBUSREQx(req[3:0]), .HLOCKx(lck[3:0]), .HSPLIT(spl[3:0]),
        .HREADY(rdy), .HRESP(rsp), .HGRANTx(g0), .HMASTER(m0), .HMASTLOCK(l0));
    ahb_arbiter_param #(.NUM_MASTERS(4), .ROUND_ROBIN(1), .DEFAULT_MASTER(0)) u_rr4 (
        .HCLK(clk), .HRESET(rst), .HBUSREQx(req[3:0]), .HLOCKx(lck[3:0]), .HSPLIT(spl[3:0]),
        .HREADY(rdy), .HRESP(rsp), .HGRANTx(g1), .HMASTER(m1), .HMASTLOCK(l1));
    ahb_arbiter_param #(.NUM_MASTERS(16), .ROUND_ROBIN(1), .DEFAULT_MASTER(5)) u_rr16 (
        .HCLK(clk), .HRESET(rst), .HBUSREQx(req), .HLOCKx(lck), .HSPLIT(spl),
        .HREADY(rdy), .HRESP(rsp), .HGRANTx(g2), .HMASTER(m2), .HMASTLOCK(l2));
    ahb_arbiter_param #(.NUM_MASTERS(2), .ROUND_ROBIN(1), .DEFAULT_MASTER(1)) u_rr2 (
        .HCLK(clk), .HRESET(rst), .HBUSREQx(req[1:0]), .HLOCKx(lck[1:0]), .HSPLIT(spl[1:0]),
        .HREADY(rdy), .HRESP(rsp), .HGRANTx(g3), .HMASTER(m3), .HMASTLOCK(l3));

    logic [15:0] dg [NC];
    logic [15:0] dm [NC];
    logic        dl [NC];
    always_comb begin
        dg[0] = {12'b0, g0}; dg[1] = {12'b0, g1}; dg[2] = g2; dg[3] = {14'b0, g3};
        dm[0] = {14'b0, m0}; dm[1] = {14'b0, m1}; dm[2] = {12'b0, m2}; dm[3] = {15'b0, m3};
        dl[0] = l0; dl[1] = l1; dl[2] = l2; dl[3] = l3;
    end

    int checks = 0;
    int errors = 0;
    bit cmp_on  = 1'b0;
    bit live_on = 1'b0;

    function automatic int cfg_n(int c);
        case (c)
            0, 1:    return 4;
            2:       return 16;
            default: return 2;
        endcase
    endfunction
    function automatic bit cfg_rr(int c);
        return c != 0;
    endfunction
    function automatic int cfg_def(int c);
        return (c == 2) ? 5 : (c == 3) ? 1 : 0;
    endfunction

    // Model state: current grant, owner of address phase, lock flag,
    // split mask, round-robin pointer, and per-master starvation counters.
    int          mg   [NC];
    int          mhm  [NC];
    bit          mlk  [NC];
    logic [15:0] mmask[NC];
    int          mptr [NC];
    int          wcnt [NC][16];

    // Returns the master the arbiter must choose, or -1 for default fallback.
    function automatic int pick(int c);
        int n = cfg_n(c);
        int g = mg[c];
        if (lck[g] && req[g]) return g;
        if (cfg_rr(c)) begin
            for (int k = 1; k <= n; k++) begin
                int i = (mptr[c] + k) % n;
                if (req[i] && !mmask[c][i]) return i;
            end
        end else begin
            for (int i = 0; i < n; i++)
                if (req[i] && !mmask[c][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(int c);
        int n = cfg_n(c);
        int p;
        logic [15:0] nm;
        if (rst) begin
            mg[c] = cfg_def(c); mhm[c] = cfg_def(c); mlk[c] = 1'b0;
            mmask[c] = '0; mptr[c] = cfg_def(c);
            for (int j = 0; j < 16; j++) wcnt[c][j] = 0;
            return;
        end
        nm = mmask[c] & ~spl;
        if (!rdy && rsp == 2'b11) nm[mhm[c]] = 1'b1;
        for (int j = n; j < 16; j++) nm[j] = 1'b0;
        if (rdy) begin
            p = pick(c);
            if (live_on && cfg_rr(c)) begin
                for (int j = 0; j < n; j++) begin
                    if (req[j] && !mmask[c][j] && p != j) wcnt[c][j]++;
                    else wcnt[c][j] = 0;
                    checks++;
                    if (wcnt[c][j] >= n) begin
                        errors++;
                        $display("FAIL starve c%0d m%0d: waited %0d ready edges, required < %0d",
                                 c, j, wcnt[c][j], n);
                        wcnt[c][j] = 0;
                    end
                end
            end
            mhm[c] = mg[c];
            mlk[c] = lck[mg[c]];
            if (p >= 0) begin
                mg[c]   = p;
                mptr[c] = p;
            end else begin
                mg[c] = cfg_def(c);
            end
        end
        mmask[c] = nm;
    endtask

    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) model_edge(c);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int c = 0; c < NC; c++) begin
                logic [15:0] eg;
                eg = 16'(1) << mg[c];
                checks++;
                if (dg[c] !== eg) begin
                    errors++;
                    $display("FAIL grant c%0d: got %h expected %h", c, dg[c], eg);
                end
                checks++;
                if (dm[c] !== 16'(mhm[c])) begin
                    errors++;
                    $display("FAIL hmaster c%0d: got %0d expected %0d", c, dm[c], mhm[c]);
                end
                checks++;
                if (dl[c] !== mlk[c]) begin
                    errors++;
                    $display("FAIL hmastlock c%0d: got %0b expected %0b", c, dl[c], mlk[c]);
                end
                checks++;
                if (!$onehot(dg[c])) begin
                    errors++;
                    $display("FAIL onehot c%0d: got %h expected one-hot", c, dg[c]);
                end
            end
        end
    end

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; lck = '0; spl = '0; rdy = 1'b1; rsp = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; lck = '0; spl = '0; rdy = 1'b1; rsp = 2'b00;
        tick(2);
        cmp_on = 1'b1;
        chk("reset fp4 grant", dg[0], 16'h0001);
        chk("reset fp4 hmaster", dm[0], 16'd0);
        chk("reset fp4 lock", {15'b0, dl[0]}, 16'd0);
        chk("reset rr16 grant", dg[2], 16'h0020);
        chk("reset rr16 hmaster", dm[2], 16'd5);
        chk("reset rr2 grant", dg[3], 16'h0002);

        // Fixed priority: lowest requesting index, then default when idle.
        rst = 1'b0; req = 16'h000A;
        tick();  chk("fp grant 1010", dg[0], 16'h0002);
        tick();  chk("fp hmaster lag", dm[0], 16'd1);
        req = '0;
        tick();  chk("fp default", dg[0], 16'h0001);

        // Round-robin rotation and wait-state hold.
        do_reset();
        req = 16'h000F;
        begin
            logic [15:0] seq [5];
            seq[0] = 16'h2; seq[1] = 16'h4; seq[2] = 16'h8; seq[3] = 16'h1; seq[4] = 16'h2;
            for (int i = 0; i < 5; i++) begin
                tick(); chk($sformatf("rr seq %0d", i), dg[1], seq[i]);
            end
        end
        rdy = 1'b0;
        tick();  chk("rr hold on wait", dg[1], 16'h0002);
        rdy = 1'b1;

        // Locked transfer hold.
        do_reset();
        req = 16'h0004; lck = 16'h0004;
        tick();  chk("lock grant 2", dg[1], 16'h0004);
        req = 16'h000F;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("lock hold rr %0d", i), dg[1], 16'h0004);
            chk($sformatf("lock hold fp %0d", i), dg[0], 16'h0004);
            chk($sformatf("mastlock %0d", i), {15'b0, dl[1]}, 16'd1);
        end
        lck = '0;
        tick();  chk("lock release rr", dg[1], 16'h0008);
        chk("lock release fp", dg[0], 16'h0001);

        // Split masking, resume, and simultaneous set/clear.
        do_reset();
        req = 16'h0002;
        tick(2); chk("split owner", dm[1], 16'd1);
        rsp = 2'b11; rdy = 1'b0;
        tick();
        rsp = 2'b00; rdy = 1'b1;
        tick();  chk("split masked rr", dg[1], 16'h0001);
        chk("split masked fp", dg[0], 16'h0001);
        spl = 16'h0002;
        tick();  chk("split clear edge", dg[1], 16'h0001);
        spl = '0;
        tick();  chk("split resumed", dg[1], 16'h0002);
        tick();  chk("split owner again", dm[1], 16'd1);
        rsp = 2'b11; rdy = 1'b0; spl = 16'h0002;
        tick();
        rsp = 2'b00; rdy = 1'b1; spl = '0;
        tick();  chk("split set wins", dg[1], 16'h0001);

        // Reset in the middle of operation.
        do_reset();
        req = 16'h0004;
        tick(2);
        rsp = 2'b11; rdy = 1'b0;
        tick();
        rsp = 2'b00; rdy = 1'b1; req = 16'h0008;
        tick();  chk("pre-reset grant 3", dg[1], 16'h0008);
        rst = 1'b1;
        tick();  chk("mid reset grant", dg[1], 16'h0001);
        chk("mid reset hmaster", dm[1], 16'd0);
        chk("mid reset lock", {15'b0, dl[1]}, 16'd0);
        rst = 1'b0; req = 16'h0004;
        tick();  chk("mask cleared", dg[1], 16'h0004);

        // Random traffic without locks (starvation tracked), then with locks.
        do_reset();
        live_on = 1'b1;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            if (cyc == 10000) live_on = 1'b0;
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
                spl[b] = ($urandom_range(0, 15) == 0);
                lck[b] = (cyc >= 10000) && ($urandom_range(0, 3) == 0);
            end
            rdy = ($urandom_range(0, 4) != 0);
            rsp = (!rdy && $urandom_range(0, 9) == 0) ? 2'b11 : 2'b00;
            tick();
        end

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
